// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for one dmem_arbiter port: held req with a one-cycle ack pulse.
// Sampling is registered inside the arbiter; requesters hold req until ack and cannot be stalled otherwise.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for single-port dmem, one transaction in flight; req->ack is 2 (write) or 2+READ_LAT (read) cycles.
// A requester is back-pressured simply by not being granted; it holds req until its ack pulse.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int READ_LAT   = 1,
    parameter int PRIO_FIXED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic          owner_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // port 0 wins the first tie
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        gnt     = 1'b0;

        if (m0.req && m1.req) begin
            gnt = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
        end else begin
            gnt = m1.req;
        end

        case (state_q)
            S_IDLE: begin
                if (m0.req || m1.req) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    we_d    = gnt ? m1.we    : m0.we;
                    addr_d  = gnt ? m1.addr  : m0.addr;
                    wdata_d = gnt ? m1.wdata : m0.wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data is valid on the last wait cycle, READ_LAT after ISSUE.
                if (cnt_q == 3'd1) begin
                    if (owner_q) rd1_d = mem_rdata_i;
                    else         rd0_d = mem_rdata_i;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_we_o    = (state_q == S_ISSUE) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign owner_o     = owner_q;

    assign m0.ack   = (state_q == S_ACK) && !owner_q;
    assign m1.ack   = (state_q == S_ACK) &&  owner_q;
    assign m0.rdata = rd0_q;
    assign m1.rdata = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: DUT A is round-robin with READ_LAT=1, DUT B is fixed-priority with READ_LAT=3.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    dmem_arbiter_if ia0 ();
    dmem_arbiter_if ia1 ();
    dmem_arbiter_if ib0 ();
    dmem_arbiter_if ib1 ();

    logic        a_mem_we, b_mem_we, a_busy, b_busy, a_owner, b_owner;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    dmem_arbiter #(.AW(32), .DW(32), .READ_LAT(1), .PRIO_FIXED(0)) u_a (
        .clk(clk), .rst_n(rst_a_n), .m0(ia0), .m1(ia1),
        .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
        .mem_rdata_i(a_mem_rdata), .busy_o(a_busy), .owner_o(a_owner)
    );

    dmem_arbiter #(.AW(32), .DW(32), .READ_LAT(3), .PRIO_FIXED(1)) u_b (
        .clk(clk), .rst_n(rst_b_n), .m0(ib0), .m1(ib1),
        .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_rdata_i(b_mem_rdata), .busy_o(b_busy), .owner_o(b_owner)
    );

    // Memory models: synchronous write, read data READ_LAT cycles after the address.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [0:2];

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
        a_pipe <= mem_a[a_mem_addr[7:2]];
        if (b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
        b_pipe[0] <= mem_b[b_mem_addr[7:2]];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mem_rdata = a_pipe;
    assign b_mem_rdata = b_pipe[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input int d, input int p, input bit rq, input bit we,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (d == 0 && p == 0) begin
            ia0.req = rq; ia0.we = we; ia0.addr = ad; ia0.wdata = wd;
        end else if (d == 0) begin
            ia1.req = rq; ia1.we = we; ia1.addr = ad; ia1.wdata = wd;
        end else if (p == 0) begin
            ib0.req = rq; ib0.we = we; ib0.addr = ad; ib0.wdata = wd;
        end else begin
            ib1.req = rq; ib1.we = we; ib1.addr = ad; ib1.wdata = wd;
        end
    endtask

    function automatic bit ack_of(input int d, input int p);
        if (d == 0) return (p == 0) ? ia0.ack : ia1.ack;
        return (p == 0) ? ib0.ack : ib1.ack;
    endfunction

    function automatic logic [31:0] rd_of(input int d, input int p);
        if (d == 0) return (p == 0) ? ia0.rdata : ia1.rdata;
        return (p == 0) ? ib0.rdata : ib1.rdata;
    endfunction

    function automatic bit memwe_of(input int d);
        return (d == 0) ? a_mem_we : b_mem_we;
    endfunction

    function automatic logic [31:0] maddr_of(input int d);
        return (d == 0) ? a_mem_addr : b_mem_addr;
    endfunction

    function automatic logic [31:0] mwdata_of(input int d);
        return (d == 0) ? a_mem_wdata : b_mem_wdata;
    endfunction

    function automatic bit busy_of(input int d);
        return (d == 0) ? a_busy : b_busy;
    endfunction

    function automatic bit any_out(input int d);
        if (d == 0)
            return |{ia0.ack, ia1.ack, ia0.rdata, ia1.rdata, a_mem_we, a_mem_addr,
                     a_mem_wdata, a_busy, a_owner};
        return |{ib0.ack, ib1.ack, ib0.rdata, ib1.rdata, b_mem_we, b_mem_addr,
                 b_mem_wdata, b_busy, b_owner};
    endfunction

    // Starts in an IDLE cycle (#1 after an edge) and returns in the following IDLE cycle.
    task automatic txn(input int d, input int p, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output int nwe, output logic [31:0] wa, output logic [31:0] wd,
                       output bit xack);
        lat = 0; rd = '0; nwe = 0; wa = '0; wd = '0; xack = 1'b0;
        drive(d, p, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (memwe_of(d)) begin
                nwe++;
                wa = maddr_of(d);
                wd = mwdata_of(d);
            end
            if (ack_of(d, 1 - p)) xack = 1'b1;
            if (ack_of(d, p)) begin
                lat = c;
                rd  = rd_of(d, p);
                break;
            end
        end
        drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk($sformatf("ack_width_d%0d_p%0d", d, p), 32'(ack_of(d, p)), 32'd0);
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_rd_a [2];
    int          lat, nwe, bad, n0, n1, k, first, second;
    logic [31:0] rd, wa, wd;
    bit          xack;
    int          order [16];

    initial begin
        vecs[0] = '{0, 1'b1, 32'h40, 32'hDEADBEEF, 2, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h40, 32'h0,        3, 32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 32'h44, 32'h12345678, 2, 32'h0};
        vecs[3] = '{0, 1'b0, 32'h44, 32'h0,        3, 32'h12345678};
        vecs[4] = '{0, 1'b1, 32'h40, 32'hCAFEF00D, 2, 32'h0};
        vecs[5] = '{1, 1'b1, 32'h80, 32'h0BADF00D, 2, 32'h0};
        vecs[6] = '{0, 1'b0, 32'h80, 32'h0,        3, 32'h0BADF00D};
        vecs[7] = '{1, 1'b0, 32'h40, 32'h0,        3, 32'hCAFEF00D};
        exp_rd_a[0] = 32'h0;
        exp_rd_a[1] = 32'h0;

        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held with random inputs: every output must stay 0.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++)
                    drive(d, p, 1'($urandom), 1'($urandom), $urandom, $urandom);
            #1;
            chk($sformatf("rst_outs_a_c%0d", c), 32'(any_out(0)), 32'd0);
            chk($sformatf("rst_outs_b_c%0d", c), 32'(any_out(1)), 32'd0);
        end
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            bad += int'(busy_of(0) | ack_of(0, 0) | ack_of(0, 1) | busy_of(1) | ack_of(1, 0) | ack_of(1, 1));
        end
        chk("post_rst_idle", bad, 0);

        // Single transactions on DUT A.
        for (int i = 0; i < 8; i++) begin
            txn(0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, nwe, wa, wd, xack);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_nwe", i), nwe, vecs[i].we ? 1 : 0);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_waddr", i), wa, vecs[i].addr);
                chk($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
            end else begin
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
                exp_rd_a[vecs[i].port] = vecs[i].exp_rd;
            end
            chk($sformatf("v%0d_other_ack", i), 32'(xack), 32'd0);
            chk($sformatf("v%0d_other_rdata", i), rd_of(0, 1 - vecs[i].port), exp_rd_a[1 - vecs[i].port]);
        end

        // Round-robin with both requests held; last owner was port 1.
        for (int i = 0; i < 16; i++) order[i] = -1;
        n0 = 0; n1 = 0; k = 0;
        drive(0, 0, 1'b1, 1'b1, 32'h20, 32'h1111);
        drive(0, 1, 1'b1, 1'b1, 32'h24, 32'h2222);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (ack_of(0, 0)) begin
                if (k < 16) order[k] = 0;
                k++; n0++;
                if (n0 == 8) drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (ack_of(0, 1)) begin
                if (k < 16) order[k] = 1;
                k++; n1++;
                if (n1 == 8) drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (n0 >= 8 && n1 >= 8) break;
        end
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("rr_acks_p0", n0, 8);
        chk("rr_acks_p1", n1, 8);
        for (int i = 0; i < 16; i++) chk($sformatf("rr_order_%0d", i), order[i], i % 2);

        // Port 0 drops req and scrambles its bus during WAIT; latched read still completes.
        lat = 0; nwe = 0; rd = '0;
        drive(0, 0, 1'b1, 1'b0, 32'h44, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 2) drive(0, 0, 1'b0, 1'b1, 32'hFFC, 32'hFFFFFFFF);
            if (a_mem_we) nwe++;
            if (ack_of(0, 0)) begin
                lat = c;
                rd  = ia0.rdata;
                break;
            end
        end
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("drop_lat", lat, 3);
        chk("drop_rdata", rd, 32'h12345678);
        chk("drop_nwe", nwe, 0);

        // req kept high through the ack cycle starts a second transaction.
        first = 0; second = 0; nwe = 0;
        drive(0, 1, 1'b1, 1'b1, 32'h30, 32'h55);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (a_mem_we) nwe++;
            if (ack_of(0, 1)) begin
                if (first == 0) first = c;
                else begin
                    second = c;
                    drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
                    break;
                end
            end
        end
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("hold_first_ack", first, 2);
        chk("hold_second_ack", second, 5);
        chk("hold_nwe", nwe, 2);

        // DUT B: READ_LAT=3.
        txn(1, 1, 1'b1, 32'h10, 32'hA5A55A5A, lat, rd, nwe, wa, wd, xack);
        chk("b_write_lat", lat, 2);
        chk("b_write_nwe", nwe, 1);
        txn(1, 0, 1'b0, 32'h10, 32'h0, lat, rd, nwe, wa, wd, xack);
        chk("b_read_lat", lat, 5);
        chk("b_read_rdata", rd, 32'hA5A55A5A);
        chk("b_read_p1_rdata", ib1.rdata, 32'h0);

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        n0 = 0; n1 = 0; bad = 0;
        drive(1, 0, 1'b1, 1'b1, 32'h50, 32'h3333);
        drive(1, 1, 1'b1, 1'b1, 32'h54, 32'h4444);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (ack_of(1, 1)) begin
                if (n0 < 6) bad++;
                else begin
                    n1++;
                    drive(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
                    break;
                end
            end
            if (ack_of(1, 0)) begin
                n0++;
                if (n0 == 6) drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("fix_p1_starved", bad, 0);
        chk("fix_p0_acks", n0, 6);
        chk("fix_p1_after", n1, 1);

        // Reset asserted during WAIT aborts the read.
        drive(1, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("b_busy_in_wait", 32'(b_busy), 32'd1);
        rst_b_n = 1'b0;
        #1;
        chk("b_rst_mid_outs", 32'(any_out(1)), 32'd0);
        drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            bad += int'(b_busy | ib0.ack | ib1.ack);
        end
        chk("b_no_ack_after_rst", bad, 0);
        txn(1, 0, 1'b0, 32'h10, 32'h0, lat, rd, nwe, wa, wd, xack);
        chk("b_post_rst_lat", lat, 5);
        chk("b_post_rst_rdata", rd, 32'hA5A55A5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
